// File: rtl/ex_forward_if.sv
// ID/EX bypass-stage bundle: ID-side instruction fields, detector results,
// forwarding sources, and the EX/MEM tracking outputs.
// Optional HAZARD_STATS_EN adds the stall_count output.
interface ex_forward_if #(
    parameter int unsigned DATA_W = 16
);
    localparam int unsigned RD_W  = 3;
    localparam int unsigned FWD_W = 2;
    localparam int unsigned CNT_W = 16;

    logic              id_valid;
    logic [DATA_W-1:0] id_rs0_data;
    logic [DATA_W-1:0] id_rs1_data;
    logic [RD_W-1:0]   id_rd;
    logic              id_reg_write;
    logic              id_mem_read;
    logic [FWD_W-1:0]  fwd_ex;
    logic [FWD_W-1:0]  fwd_mem;
    logic              flush;
    logic [DATA_W-1:0] ex_result;
    logic [DATA_W-1:0] mem_wdata;

    logic              stall;
    logic              ex_valid;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic [RD_W-1:0]   ex_rd;
    logic [DATA_W-1:0] ex_op0;
    logic [DATA_W-1:0] ex_op1;
    logic              mem_valid;
    logic              mem_reg_write;
    logic [RD_W-1:0]   mem_rd;
`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_rs0_data, id_rs1_data, id_rd, id_reg_write,
               id_mem_read, fwd_ex, fwd_mem, flush, ex_result, mem_wdata,
        input  stall, ex_valid, ex_reg_write, ex_mem_read, ex_rd, ex_op0,
               ex_op1, mem_valid, mem_reg_write, mem_rd, stall_count
    );

    modport slave (
        input  id_valid, id_rs0_data, id_rs1_data, id_rd, id_reg_write,
               id_mem_read, fwd_ex, fwd_mem, flush, ex_result, mem_wdata,
        output stall, ex_valid, ex_reg_write, ex_mem_read, ex_rd, ex_op0,
               ex_op1, mem_valid, mem_reg_write, mem_rd, stall_count
    );
`else
    modport master (
        output id_valid, id_rs0_data, id_rs1_data, id_rd, id_reg_write,
               id_mem_read, fwd_ex, fwd_mem, flush, ex_result, mem_wdata,
        input  stall, ex_valid, ex_reg_write, ex_mem_read, ex_rd, ex_op0,
               ex_op1, mem_valid, mem_reg_write, mem_rd
    );

    modport slave (
        input  id_valid, id_rs0_data, id_rs1_data, id_rd, id_reg_write,
               id_mem_read, fwd_ex, fwd_mem, flush, ex_result, mem_wdata,
        output stall, ex_valid, ex_reg_write, ex_mem_read, ex_rd, ex_op0,
               ex_op1, mem_valid, mem_reg_write, mem_rd
    );
`endif
endinterface

// File: rtl/ex_forward_stage.sv
// ID/EX pipeline register with operand bypass from EX and MEM, load-use
// stall/bubble insertion, and EX/MEM destination tracking for the hazard
// detectors. Optional HAZARD_STATS_EN adds a saturating stall counter.
module ex_forward_stage (
    input  logic        clk,
    input  logic        rst_n,
    ex_forward_if.slave bus
);
    localparam int unsigned DATA_W = $bits(bus.ex_op0);
    localparam int unsigned RD_W   = $bits(bus.ex_rd);
    localparam int unsigned FWD_W  = 2;

    typedef enum logic {
        RUN       = 1'b0,
        LU_BUBBLE = 1'b1
    } state_t;

    state_t            state;
    logic [FWD_W-1:0]  ex_hit_c;
    logic [FWD_W-1:0]  mem_hit_c;
    logic              load_use_c;
    logic              stall_c;
    logic              bubble_c;
    logic [DATA_W-1:0] op0_c;
    logic [DATA_W-1:0] op1_c;

    // Qualified detector hits, load-use detection and operand bypass muxes
    always_comb begin
        ex_hit_c   = '0;
        mem_hit_c  = '0;
        for (int k = 0; k < int'(FWD_W); k++) begin
            ex_hit_c[k]  = bus.id_valid & bus.fwd_ex[k]
                         & bus.ex_valid & bus.ex_reg_write;
            mem_hit_c[k] = bus.id_valid & bus.fwd_mem[k]
                         & bus.mem_valid & bus.mem_reg_write;
        end
        load_use_c = (|ex_hit_c) & bus.ex_mem_read;
        // Only RUN can stall, so a load-use costs exactly one cycle
        stall_c    = (state == RUN) & load_use_c & ~bus.flush;
        bubble_c   = stall_c | bus.flush;

        op0_c = bus.id_rs0_data;
        if (ex_hit_c[0]) begin
            op0_c = bus.ex_result;
        end else if (mem_hit_c[0]) begin
            op0_c = bus.mem_wdata;
        end

        op1_c = bus.id_rs1_data;
        if (ex_hit_c[1]) begin
            op1_c = bus.ex_result;
        end else if (mem_hit_c[1]) begin
            op1_c = bus.mem_wdata;
        end
    end

    assign bus.stall = stall_c;

    // FSM plus ID/EX and EX/MEM registers; EX and MEM never hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= RUN;
            bus.ex_valid      <= 1'b0;
            bus.ex_reg_write  <= 1'b0;
            bus.ex_mem_read   <= 1'b0;
            bus.ex_rd         <= '0;
            bus.ex_op0        <= '0;
            bus.ex_op1        <= '0;
            bus.mem_valid     <= 1'b0;
            bus.mem_reg_write <= 1'b0;
            bus.mem_rd        <= '0;
        end else begin
            state <= stall_c ? LU_BUBBLE : RUN;

            if (bubble_c) begin
                bus.ex_valid     <= 1'b0;
                bus.ex_reg_write <= 1'b0;
                bus.ex_mem_read  <= 1'b0;
                bus.ex_rd        <= '0;
                bus.ex_op0       <= '0;
                bus.ex_op1       <= '0;
            end else begin
                bus.ex_valid     <= bus.id_valid;
                bus.ex_reg_write <= bus.id_reg_write;
                bus.ex_mem_read  <= bus.id_mem_read;
                bus.ex_rd        <= RD_W'(bus.id_rd);
                bus.ex_op0       <= op0_c;
                bus.ex_op1       <= op1_c;
            end

            bus.mem_valid     <= bus.ex_valid;
            bus.mem_reg_write <= bus.ex_reg_write;
            bus.mem_rd        <= bus.ex_rd;
        end
    end

`ifdef HAZARD_STATS_EN
    localparam int unsigned CNT_W = $bits(bus.stall_count);

    // Saturating count of stall cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.stall_count <= '0;
        end else if (stall_c && (bus.stall_count != {CNT_W{1'b1}})) begin
            bus.stall_count <= bus.stall_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ex_forward_stage.sv
// Directed-vector bench for ex_forward_stage with a queue-based scoreboard.
// Honours HAZARD_STATS_EN for the stall_count check.
module tb_ex_forward_stage;
    localparam int unsigned DATA_W = 16;

    typedef struct {
        logic        chk_stall;
        logic        stall;
        logic        ex_valid;
        logic        ex_rw;
        logic        ex_mr;
        logic [2:0]  ex_rd;
        logic [15:0] op0;
        logic [15:0] op1;
        logic        mem_valid;
        logic        mem_rw;
        logic [2:0]  mem_rd;
        logic [15:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    ex_forward_if #(.DATA_W(DATA_W)) bus ();

    ex_forward_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t q[$];
    exp_t pend;
    logic pend_valid = 1'b0;
    int   n_applied  = 0;
    int   n_checked  = 0;
    int   n_cmp      = 0;
    int   n_bad      = 0;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp, input int idx);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL vec%0d %s: got 0x%0h expected 0x%0h", idx, name, act, exp);
        end
    endtask

    // Drive one vector after a rising edge and queue its expected response
    task automatic apply(
        input logic r, input logic v, input logic [15:0] rs0, input logic [15:0] rs1,
        input logic [2:0] rd, input logic rw, input logic mr,
        input logic [1:0] fe, input logic [1:0] fm, input logic fl,
        input logic [15:0] exr, input logic [15:0] mw,
        input logic cs, input logic es,
        input logic ev, input logic erw, input logic emr, input logic [2:0] erd,
        input logic [15:0] eo0, input logic [15:0] eo1,
        input logic mv, input logic mrw, input logic [2:0] mrd, input logic [15:0] cnt);
        exp_t e;
        @(posedge clk);
        #2;
        rst_n            = r;
        bus.id_valid     = v;
        bus.id_rs0_data  = rs0;
        bus.id_rs1_data  = rs1;
        bus.id_rd        = rd;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        bus.fwd_ex       = fe;
        bus.fwd_mem      = fm;
        bus.flush        = fl;
        bus.ex_result    = exr;
        bus.mem_wdata    = mw;
        e = '{chk_stall: cs, stall: es, ex_valid: ev, ex_rw: erw, ex_mr: emr,
              ex_rd: erd, op0: eo0, op1: eo1, mem_valid: mv, mem_rw: mrw,
              mem_rd: mrd, cnt: cnt};
        q.push_back(e);
        n_applied++;
    endtask

    // Monitor: stall late in the drive cycle, registers just after the next edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pend_valid) begin
                cmp("ex_valid",      16'(bus.ex_valid),      16'(pend.ex_valid),  n_checked);
                cmp("ex_reg_write",  16'(bus.ex_reg_write),  16'(pend.ex_rw),     n_checked);
                cmp("ex_mem_read",   16'(bus.ex_mem_read),   16'(pend.ex_mr),     n_checked);
                cmp("ex_rd",         16'(bus.ex_rd),         16'(pend.ex_rd),     n_checked);
                cmp("ex_op0",        bus.ex_op0,             pend.op0,            n_checked);
                cmp("ex_op1",        bus.ex_op1,             pend.op1,            n_checked);
                cmp("mem_valid",     16'(bus.mem_valid),     16'(pend.mem_valid), n_checked);
                cmp("mem_reg_write", 16'(bus.mem_reg_write), 16'(pend.mem_rw),    n_checked);
                cmp("mem_rd",        16'(bus.mem_rd),        16'(pend.mem_rd),    n_checked);
`ifdef HAZARD_STATS_EN
                cmp("stall_count",   bus.stall_count,        pend.cnt,            n_checked);
`endif
                n_checked++;
                pend_valid = 1'b0;
            end
            #7;
            if (q.size() > 0) begin
                pend = q.pop_front();
                pend_valid = 1'b1;
                if (pend.chk_stall)
                    cmp("stall", 16'(bus.stall), 16'(pend.stall), n_checked);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.id_valid = 1'b0; bus.id_rs0_data = '0; bus.id_rs1_data = '0;
        bus.id_rd = '0; bus.id_reg_write = 1'b0; bus.id_mem_read = 1'b0;
        bus.fwd_ex = '0; bus.fwd_mem = '0; bus.flush = 1'b0;
        bus.ex_result = '0; bus.mem_wdata = '0;

        //     rst v  rs0       rs1       rd rw mr fe     fm     fl exr       mw         cs st  ev rw mr rd op0       op1       mv rw rd cnt
        // reset, two cycles, random inputs
        apply(0, 1'($urandom), 16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
              2'($urandom), 2'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                                                                       0, 0,  0, 0, 0, 0, 16'h0,    16'h0,    0, 0, 0, 16'd0);
        apply(0, 1'($urandom), 16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
              2'($urandom), 2'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                                                                       1, 0,  0, 0, 0, 0, 16'h0,    16'h0,    0, 0, 0, 16'd0);
        // ALU write r3
        apply(1, 1, 16'h0011, 16'h0022, 3, 1, 0, 2'b00, 2'b00, 0, 16'h0000, 16'h0000,
                                                                       1, 0,  1, 1, 0, 3, 16'h0011, 16'h0022, 0, 0, 0, 16'd0);
        // EX forward r3 -> rs0
        apply(1, 1, 16'h0000, 16'h0777, 4, 1, 0, 2'b01, 2'b00, 0, 16'h1234, 16'h0000,
                                                                       1, 0,  1, 1, 0, 4, 16'h1234, 16'h0777, 1, 1, 3, 16'd0);
        // EX and MEM both hit rs1: EX wins
        apply(1, 1, 16'h0101, 16'h0202, 6, 1, 0, 2'b10, 2'b10, 0, 16'hAAAA, 16'h5555,
                                                                       1, 0,  1, 1, 0, 6, 16'h0101, 16'hAAAA, 1, 1, 4, 16'd0);
        // load r5, MEM-only hit on rs0
        apply(1, 1, 16'h0303, 16'h0404, 5, 1, 1, 2'b00, 2'b01, 0, 16'h0000, 16'h5A5A,
                                                                       1, 0,  1, 1, 1, 5, 16'h5A5A, 16'h0404, 1, 1, 6, 16'd0);
        // load-use on rs1: stall, bubble
        apply(1, 1, 16'h0606, 16'h0000, 2, 1, 0, 2'b10, 2'b00, 0, 16'hDEAD, 16'h0000,
                                                                       1, 1,  0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 5, 16'd1);
        // LU_BUBBLE: same instruction resolves through MEM
        apply(1, 1, 16'h0606, 16'h0000, 2, 1, 0, 2'b00, 2'b10, 0, 16'h0000, 16'hBEEF,
                                                                       1, 0,  1, 1, 0, 2, 16'h0606, 16'hBEEF, 0, 0, 0, 16'd1);
        // load r7
        apply(1, 1, 16'h0808, 16'h0909, 7, 1, 1, 2'b00, 2'b00, 0, 16'h0000, 16'h0000,
                                                                       1, 0,  1, 1, 1, 7, 16'h0808, 16'h0909, 1, 1, 2, 16'd1);
        // flush during load-use detection: no stall, bubble
        apply(1, 1, 16'h0000, 16'h0000, 3, 1, 0, 2'b01, 2'b00, 1, 16'h0000, 16'h0000,
                                                                       1, 0,  0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 7, 16'd1);
        // back in RUN: EX bubble gives no hit, MEM hit on rs0
        apply(1, 1, 16'h0000, 16'h0A0A, 4, 1, 0, 2'b01, 2'b01, 0, 16'h7777, 16'h1357,
                                                                       1, 0,  1, 1, 0, 4, 16'h1357, 16'h0A0A, 0, 0, 0, 16'd1);
        // load r5
        apply(1, 1, 16'h0B0B, 16'h0C0C, 5, 1, 1, 2'b00, 2'b00, 0, 16'h0000, 16'h0000,
                                                                       1, 0,  1, 1, 1, 5, 16'h0B0B, 16'h0C0C, 1, 1, 4, 16'd1);
        // load-use on rs0
        apply(1, 1, 16'h0000, 16'h0D0D, 6, 1, 0, 2'b01, 2'b00, 0, 16'h0000, 16'h0000,
                                                                       1, 1,  0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 5, 16'd2);
        // reset while in LU_BUBBLE
        apply(0, 1, 16'h0000, 16'h0D0D, 6, 1, 0, 2'b00, 2'b01, 0, 16'h0000, 16'h4444,
                                                                       1, 0,  0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'd0);
        // after reset: RUN, non-writing instruction r1
        apply(1, 1, 16'h1111, 16'h2222, 1, 0, 0, 2'b00, 2'b00, 0, 16'h0000, 16'h0000,
                                                                       1, 0,  1, 0, 0, 1, 16'h1111, 16'h2222, 0, 0, 0, 16'd0);
        // detector match on a non-writing EX instruction is not a hit
        apply(1, 1, 16'h3333, 16'h4444, 2, 1, 0, 2'b11, 2'b00, 0, 16'hFFFF, 16'h0000,
                                                                       1, 0,  1, 1, 0, 2, 16'h3333, 16'h4444, 1, 0, 1, 16'd0);
        // id_valid=0 masks detector matches
        apply(1, 0, 16'h0000, 16'h0000, 0, 0, 0, 2'b11, 2'b00, 0, 16'h9999, 16'h0000,
                                                                       1, 0,  0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 2, 16'd0);
        // flush with no hazard
        apply(1, 1, 16'h0001, 16'h0002, 3, 1, 0, 2'b00, 2'b00, 1, 16'h0000, 16'h0000,
                                                                       1, 0,  0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'd0);

        repeat (3) @(posedge clk);
        #3;
        n_cmp++;
        if (n_checked != n_applied || q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: checked %0d of %0d vectors, %0d left queued", n_checked, n_applied, q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_bad);
        $finish;
    end

    // Hard time bound
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1);
    end
endmodule
